dcp_frame_ctrl: RTL and testbench

Frame-level sequencer for the dark-channel-prior dehaze pipeline. Tracks frame timing from vsync/de and scans the incoming dark-channel stream for its per-frame maximum. At each frame boundary it commits the atmospheric light value A used by the transmittance and recovery stages. It also emits pixel coordinates, frame strobes and a frame-size check.

---
 rtl/dcp_frame_ctrl_if.sv | 35 +++
 rtl/dcp_frame_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_dcp_frame_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dcp_frame_ctrl_if.sv
// Video-side bundle for the dark-channel-prior frame controller.
// The "master" modport is the pixel source / downstream consumer side
// (drives sync, enable and dark-channel data, observes the frame results).
// The "slave" modport is the frame controller itself.
interface dcp_frame_ctrl_if;
    // Incoming dark-channel stream and frame timing
    logic        i_vsync;
    logic        i_de;
    logic [7:0]  i_dark;

    // Atmospheric light and frame status
    logic [7:0]  o_atmos;
    logic        o_atmos_upd;
    logic        o_frame_start;
    logic        o_frame_done;
    logic        o_size_err;
    logic [1:0]  o_state;

    // Registered pixel position
    logic        o_pix_valid;
    logic [11:0] o_pix_x;
    logic [11:0] o_pix_y;

    modport master (
        output i_vsync, i_de, i_dark,
        input  o_atmos, o_atmos_upd, o_frame_start, o_frame_done,
               o_size_err, o_state, o_pix_valid, o_pix_x, o_pix_y
    );

    modport slave (
        input  i_vsync, i_de, i_dark,
        output o_atmos, o_atmos_upd, o_frame_start, o_frame_done,
               o_size_err, o_state, o_pix_valid, o_pix_x, o_pix_y
    );
endinterface

// File: rtl/dcp_frame_ctrl.sv
// Frame-level sequencer for the dark-channel-prior dehaze pipeline.
//
// Tracks frame timing from vsync/de, scans the dark-channel stream for its
// per-frame maximum and, at each frame boundary, commits the atmospheric
// light A used by the transmittance and recovery stages. A only changes at
// a commit, so downstream sees a stable value for a whole frame.
//
// A frame commits only if exactly H_ACTIVE*V_ACTIVE pixels were seen;
// otherwise a size error is flagged and A is held.
//
// Optional feature macro: DCP_ATMOS_IIR_EN
//   undefined (default): A_new = max(run_max, A_MIN)
//   defined            : A_new = (3*A + max(run_max, A_MIN)) >> 2, with the
//                        first valid commit after reset loading the floored
//                        maximum directly.
module dcp_frame_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter logic [7:0]  A_INIT   = 8'd255,
    parameter logic [7:0]  A_MIN    = 8'd100
) (
    input  logic            pixelclk,
    input  logic            reset_n,
    dcp_frame_ctrl_if.slave vid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_DE = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    localparam logic [23:0] FRAME_PIXELS = 24'(H_ACTIVE * V_ACTIVE);
    localparam logic [11:0] X_LAST       = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_MAX        = 12'hFFF;
    localparam logic [23:0] CNT_MAX      = 24'hFF_FFFF;

    state_t      state;
    logic        vsync_q;
    logic        vsync_rise;
    logic        accept;

    // Per-frame accumulation
    logic [7:0]  run_max;
    logic [23:0] pix_cnt;
    logic        frame_ok;
    logic [7:0]  max_floor;
    logic [7:0]  atmos_new;

    // Position of the next accepted pixel
    logic [11:0] x_cnt;
    logic [11:0] y_cnt;

    // Registered outputs
    logic [7:0]  atmos_q;
    logic        atmos_upd_q;
    logic        frame_start_q;
    logic        frame_done_q;
    logic        size_err_q;
    logic        pix_valid_q;
    logic [11:0] pix_x_q;
    logic [11:0] pix_y_q;

    assign vsync_rise = vid.i_vsync & ~vsync_q;

    // Pixels only count while a frame is open; IDLE and COMMIT drop them.
    assign accept    = vid.i_de & ((state == ST_WAIT_DE) | (state == ST_ACTIVE));

    assign frame_ok  = (pix_cnt == FRAME_PIXELS);
    assign max_floor = (run_max > A_MIN) ? run_max : A_MIN;

`ifdef DCP_ATMOS_IIR_EN
    // Set once the first valid frame has loaded A; from then on A is filtered.
    logic       first_done;
    logic [9:0] iir_sum;

    // 3*A + m fits in 10 bits (max 1020); the divide by 4 truncates.
    assign iir_sum   = ({2'b00, atmos_q} << 1) + {2'b00, atmos_q} + {2'b00, max_floor};
    assign atmos_new = first_done ? iir_sum[9:2] : max_floor;

    // Track whether a valid commit has happened since reset
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            first_done <= 1'b0;
        end else if ((state == ST_COMMIT) && frame_ok) begin
            first_done <= 1'b1;
        end
    end
`else
    assign atmos_new = max_floor;
`endif

    // Edge detector for the frame sync
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
        end else begin
            // NOTE: state elements use non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            vsync_q <= vid.i_vsync;
        end
    end

    // Frame FSM with its registered strobes and the committed A
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            atmos_q       <= A_INIT;
            atmos_upd_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            size_err_q    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            atmos_upd_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            size_err_q    <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (vsync_rise) begin
                        state <= ST_WAIT_DE;
                    end
                end

                // A vsync edge with no pixels yet is an empty frame: stay put.
                ST_WAIT_DE: begin
                    if (vid.i_de) begin
                        state         <= ST_ACTIVE;
                        frame_start_q <= 1'b1;
                    end
                end

                // frame_done is set on entry so it is high during COMMIT.
                ST_ACTIVE: begin
                    if (vsync_rise) begin
                        state        <= ST_COMMIT;
                        frame_done_q <= 1'b1;
                    end
                end

                // run_max/pix_cnt are final here, including a pixel that
                // coincided with the closing vsync edge.
                ST_COMMIT: begin
                    state <= ST_WAIT_DE;
                    if (frame_ok) begin
                        atmos_q     <= atmos_new;
                        atmos_upd_q <= 1'b1;
                    end else begin
                        size_err_q  <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Running maximum and saturating pixel count for the open frame
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            run_max <= 8'd0;
            pix_cnt <= 24'd0;
        end else if (state == ST_COMMIT) begin
            run_max <= 8'd0;
            pix_cnt <= 24'd0;
        end else if (accept) begin
            if (vid.i_dark > run_max) begin
                run_max <= vid.i_dark;
            end
            if (pix_cnt != CNT_MAX) begin
                pix_cnt <= pix_cnt + 24'd1;
            end
        end
    end

    // Pixel coordinates, registered one cycle behind the accepted de
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt       <= 12'd0;
            y_cnt       <= 12'd0;
            pix_x_q     <= 12'd0;
            pix_y_q     <= 12'd0;
            pix_valid_q <= 1'b0;
        end else begin
            pix_valid_q <= accept;
            if (state == ST_COMMIT) begin
                x_cnt   <= 12'd0;
                y_cnt   <= 12'd0;
                pix_x_q <= 12'd0;
                pix_y_q <= 12'd0;
            end else if (accept) begin
                pix_x_q <= x_cnt;
                pix_y_q <= y_cnt;
                if (x_cnt == X_LAST) begin
                    x_cnt <= 12'd0;
                    if (y_cnt != Y_MAX) begin
                        y_cnt <= y_cnt + 12'd1;
                    end
                end else begin
                    x_cnt <= x_cnt + 12'd1;
                end
            end
        end
    end

    assign vid.o_atmos       = atmos_q;
    assign vid.o_atmos_upd   = atmos_upd_q;
    assign vid.o_frame_start = frame_start_q;
    assign vid.o_frame_done  = frame_done_q;
    assign vid.o_size_err    = size_err_q;
    assign vid.o_state       = state;
    assign vid.o_pix_valid   = pix_valid_q;
    assign vid.o_pix_x       = pix_x_q;
    assign vid.o_pix_y       = pix_y_q;

endmodule

// File: tb/tb_dcp_frame_ctrl.sv
// Directed bench for dcp_frame_ctrl with a 4x2 frame and A_MIN = 100.
// Expected A values are hand-computed for both builds of the IIR option.
module tb_dcp_frame_ctrl;

    logic pixelclk = 1'b0;
    logic reset_n;

    dcp_frame_ctrl_if vid ();

    dcp_frame_ctrl #(
        .H_ACTIVE (4),
        .V_ACTIVE (2),
        .A_INIT   (8'd255),
        .A_MIN    (8'd100)
    ) dut (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .vid      (vid)
    );

    always #5 pixelclk = ~pixelclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pix [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs for one clock edge, then settle just after it.
    task automatic step(input logic vs, input logic de, input logic [7:0] d);
        vid.i_vsync = vs;
        vid.i_de    = de;
        vid.i_dark  = d;
        @(posedge pixelclk);
        #1;
    endtask

    // Open a frame, stream n pixels from pix[], close it and check the commit.
    task automatic run_frame(input string name, input int n, input bit coincide,
                             input logic [7:0] exp_atmos, input bit exp_ok);
        step(1'b1, 1'b0, 8'd0);
        check($sformatf("%s open_state", name), vid.o_state, 1);
        check($sformatf("%s open_done", name), vid.o_frame_done, 0);
        step(1'b0, 1'b0, 8'd0);

        for (int i = 0; i < n; i++) begin
            if (coincide && (i == n - 1)) step(1'b1, 1'b1, pix[i]);
            else                          step(1'b0, 1'b1, pix[i]);
            check($sformatf("%s valid[%0d]", name, i), vid.o_pix_valid, 1);
            check($sformatf("%s x[%0d]", name, i), vid.o_pix_x, i % 4);
            check($sformatf("%s y[%0d]", name, i), vid.o_pix_y, i / 4);
            check($sformatf("%s start[%0d]", name, i), vid.o_frame_start, (i == 0) ? 1 : 0);
        end

        if (!coincide) step(1'b1, 1'b0, 8'd0);
        check($sformatf("%s commit_state", name), vid.o_state, 3);
        check($sformatf("%s frame_done", name), vid.o_frame_done, 1);
        check($sformatf("%s upd_early", name), vid.o_atmos_upd, 0);

        step(1'b0, 1'b0, 8'd0);
        check($sformatf("%s atmos", name), vid.o_atmos, exp_atmos);
        check($sformatf("%s atmos_upd", name), vid.o_atmos_upd, exp_ok ? 1 : 0);
        check($sformatf("%s size_err", name), vid.o_size_err, exp_ok ? 0 : 1);
        check($sformatf("%s done_clear", name), vid.o_frame_done, 0);
        check($sformatf("%s post_state", name), vid.o_state, 1);
        check($sformatf("%s pix_x_clear", name), vid.o_pix_x, 0);

        step(1'b0, 1'b0, 8'd0);
        check($sformatf("%s upd_drop", name), vid.o_atmos_upd, 0);
        check($sformatf("%s atmos_hold", name), vid.o_atmos, exp_atmos);
    endtask

    initial begin
        vid.i_vsync = 1'b0;
        vid.i_de    = 1'b0;
        vid.i_dark  = 8'd0;
        reset_n     = 1'b0;

        // 1. Reset state
        repeat (3) @(posedge pixelclk);
        #1;
        check("rst atmos", vid.o_atmos, 255);
        check("rst state", vid.o_state, 0);
        check("rst upd", vid.o_atmos_upd, 0);
        check("rst done", vid.o_frame_done, 0);
        check("rst start", vid.o_frame_start, 0);
        check("rst size_err", vid.o_size_err, 0);
        check("rst valid", vid.o_pix_valid, 0);
        reset_n = 1'b1;

        // Pixels while IDLE are ignored.
        step(1'b0, 1'b1, 8'd250);
        check("idle valid", vid.o_pix_valid, 0);
        check("idle state", vid.o_state, 0);

        // 2. Valid frame, max 200
        pix = '{8'd10, 8'd50, 8'd200, 8'd30, 8'd7, 8'd180, 8'd90, 8'd1};
        run_frame("valid", 8, 1'b0, 8'd200, 1'b1);

        // 3. Floor: all 40 -> m = 100
        pix = '{8'd40, 8'd40, 8'd40, 8'd40, 8'd40, 8'd40, 8'd40, 8'd40};
`ifdef DCP_ATMOS_IIR_EN
        run_frame("floor", 8, 1'b0, 8'd175, 1'b1);   // (600+100)>>2
`else
        run_frame("floor", 8, 1'b0, 8'd100, 1'b1);
`endif

        // 4. Short frame holds A, then a valid frame with max 150
        pix = '{8'd5, 8'd60, 8'd250, 8'd3, 8'd4, 8'd6, 8'd8, 8'd0};
`ifdef DCP_ATMOS_IIR_EN
        run_frame("short", 7, 1'b0, 8'd175, 1'b0);
        pix = '{8'd150, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        run_frame("after_short", 8, 1'b0, 8'd168, 1'b1); // (525+150)>>2
`else
        run_frame("short", 7, 1'b0, 8'd100, 1'b0);
        pix = '{8'd150, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        run_frame("after_short", 8, 1'b0, 8'd150, 1'b1);
`endif

        // 5. Eighth pixel coincides with vsync_rise and carries the max
        pix = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd220};
`ifdef DCP_ATMOS_IIR_EN
        run_frame("coincide", 8, 1'b1, 8'd181, 1'b1);    // (504+220)>>2
`else
        run_frame("coincide", 8, 1'b1, 8'd220, 1'b1);
`endif

        // 6. Mid-frame reset after three pixels
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd240);
        step(1'b0, 1'b1, 8'd241);
        step(1'b0, 1'b1, 8'd242);
        reset_n = 1'b0;
        #1;
        check("midrst state", vid.o_state, 0);
        check("midrst atmos", vid.o_atmos, 255);
        check("midrst valid", vid.o_pix_valid, 0);
        check("midrst pix_y", vid.o_pix_y, 0);
        step(1'b0, 1'b0, 8'd0);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        check("postrst state", vid.o_state, 0);

        // Two frames after reset: max 200 then 100
        pix = '{8'd20, 8'd200, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        run_frame("rst_f1", 8, 1'b0, 8'd200, 1'b1);
        pix = '{8'd100, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
`ifdef DCP_ATMOS_IIR_EN
        run_frame("rst_f2", 8, 1'b0, 8'd175, 1'b1);      // (600+100)>>2
`else
        run_frame("rst_f2", 8, 1'b0, 8'd100, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
